switch_allocator: RTL
=====================

# switch_allocator

Separable input-first switch allocator for one router. Each cycle it takes the VC buffer status and routing results of all input ports. It grants at most one VC per input port and at most one input port per output port. The grants are registered and drive the input ports' VC select (`vc_sel_i`/`valid_sel_i`) and the crossbar select lines. Fairness comes from round-robin pointers at both arbitration stages.

## Interface
Parameters:
- `VC_NUM`, default `noc_params::VC_NUM`: virtual channels per port.
- `PORT_NUM`, default `noc_params::PORT_NUM` (5): router ports, which are also the output ports.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `is_empty_i[PORT_NUM]`  in  VC_NUM  per-input VC buffer empty flags.
- `vc_ready_i[PORT_NUM]`  in  VC_NUM  per-input VC has a downstream VC allocated.
- `out_port_i[PORT_NUM][VC_NUM]`  in  port_t  routed output port per input VC.
- `down_vc_i[PORT_NUM][VC_NUM]`  in  VC_SIZE  allocated downstream VC per input VC.
- `on_off_i[PORT_NUM]`  in  VC_NUM  downstream on/off per output port and downstream VC.
- `valid_sel_o[PORT_NUM]`  out  1  read strobe to input port i.
- `vc_sel_o[PORT_NUM]`  out  VC_SIZE  VC to read at input port i.
- `xb_valid_o[PORT_NUM]`  out  1  output port o carries a flit.
- `xb_sel_o[PORT_NUM]`  out  PORT_SIZE  input port index routed to output o.

## Operation
- **Request.** Input VC (i,v) requests when all of the following hold:
  - `!is_empty_i[i][v]`
  - `vc_ready_i[i][v]`
  - it is not masked (see below)
  - the on/off filter passes.
- **Stage 1 (per input).** A round-robin arbiter over the VC_NUM requests picks VC w_i. Input i then bids for output `out_port_i[i][w_i]`.
- **Stage 2 (per output).** A round-robin arbiter over the PORT_NUM bidding inputs picks input g_o.
- **Grant.** Input g_o, VC w_{g_o} wins. The outputs register:
  - `valid_sel_o[g_o]=1`
  - `vc_sel_o[g_o]=w`
  - `xb_valid_o[o]=1`
  - `xb_sel_o[o]=g_o`
- **Pointer update on final grant only.**
  - Stage-1 pointer of input g_o becomes (w+1) mod VC_NUM.
  - Stage-2 pointer of output o becomes (g_o+1) mod PORT_NUM.
  - An input that loses stage 2 keeps its stage-1 pointer.
- **Re-grant mask.** A VC granted in cycle n is masked in cycle n+1. This covers the one-cycle lag of `is_empty_i` after a read, so the allocator never issues a read to a buffer that may have just emptied.
- **Arithmetic.** Pointers are modulo counters that wrap from VC_NUM-1 to 0 and from PORT_NUM-1 to 0.
- **No-request cycle.** All valid outputs are 0, and `vc_sel_o`/`xb_sel_o` hold their previous values.
- **Invariants.**
  - Each asserted `valid_sel_o[i]` appears in exactly one `xb_sel_o` with `xb_valid_o` set.
  - No two outputs select the same input.

## Timing
- Request inputs are sampled at posedge n. Grant outputs are valid from posedge n+1 for one cycle. Latency is 1.
- Reset values:
  - all `valid_sel_o`, `xb_valid_o` = 0
  - all `vc_sel_o`, `xb_sel_o` = 0
  - all pointers = 0
  - re-grant mask cleared
- Reset asserted mid-operation clears grants asynchronously. The first grant after release is at the second posedge after `rst` falls.
- **Simultaneous events:**
  - Under full contention (all inputs, one output), each input is granted once every PORT_NUM cycles.
  - A single VC with continuous data is granted every other cycle (mask).
  - Two VCs of the same input alternate and can sustain one grant per cycle.

## Configuration
- **`SA_ONOFF_FILTER_EN` defined:** request (i,v) additionally requires `on_off_i[out_port_i[i][v]][down_vc_i[i][v]]==1`, and an off VC never bids.
- **Undefined:** `on_off_i` and `down_vc_i` are ignored (the ports remain), and downstream flow control is enforced outside this block.

## Structure
- `noc_params` holds the shared types and constants:
  - `port_t`
  - `PORT_NUM`
  - `PORT_SIZE = $clog2(PORT_NUM)`
  - `VC_NUM`
  - `VC_SIZE`
- Sub-module `round_robin_arbiter #(N)`:
  - ports: `clk`, `rst`, `requests_i[N]`, `update_i`, `grant_o[N]` (one-hot, combinational)
  - holds the pointer internally; the pointer advances past the granted index when `update_i`=1
  - instantiated PORT_NUM times with N=VC_NUM and PORT_NUM times with N=PORT_NUM

## Test plan
- **Reset.** `rst`=1 with arbitrary inputs → all outputs 0. After release with input 0 VC 1 requesting output 2 → `valid_sel_o[0]=1`, `vc_sel_o[0]=1`, `xb_valid_o[2]=1`, `xb_sel_o[2]=0` one cycle later.
- **Output contention.** All 5 inputs continuously request output 0 on alternating VCs → grant order 0,1,2,3,4,0; exactly one `xb_valid_o` per cycle.
- **Intra-input VC round-robin.** Input 1 with VC0 and VC1 both non-empty to different free outputs → `vc_sel_o[1]` alternates 0,1,0,1 with `valid_sel_o[1]` held high.
- **Mask.** Only input 3 VC0 requesting → `valid_sel_o[3]` toggles 1,0,1,0; it never asserts on two consecutive cycles.
- **On/off.** With `SA_ONOFF_FILTER_EN`, setting `on_off_i[2][down_vc]=0` for input 0's target → no grant until the bit returns to 1, then a grant the next cycle. Without the macro → a grant regardless of `on_off_i`.
- **Stage-2 loss.** Inputs 0 and 1 request output 4 while input 1 also has a VC for output 3 → input 1's stage-1 pointer is unchanged after losing; no output selects the same input twice.

Source files
------------

// File: rtl/noc_params.sv
// Shared router constants and types for the switch allocator.
package noc_params;

    localparam int unsigned PORT_NUM  = 5;
    localparam int unsigned PORT_SIZE = $clog2(PORT_NUM);
    localparam int unsigned VC_NUM    = 2;
    localparam int unsigned VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef logic [PORT_SIZE-1:0] port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a combinational one-hot grant; the pointer moves
// just past the granted index when update_i is high.
module round_robin_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] requests_i,
    input  logic         update_i,
    output logic [N-1:0] grant_o
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gidx;
    logic [N-1:0]  w_hi_mask;
    logic [N-1:0]  w_sel;

    // Requests at or above the pointer take priority; otherwise wrap to the bottom.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_hi_mask[j] = (PW'(j) >= r_ptr);
        end
        w_sel = (|(requests_i & w_hi_mask)) ? (requests_i & w_hi_mask) : requests_i;
        w_gidx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_sel[j]) begin
                w_gidx = PW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            grant_o[j] = (|w_sel) && (PW'(j) == w_gidx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (update_i && (|requests_i)) begin
            r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with registered grants.
// Define SA_ONOFF_FILTER_EN to gate requests with downstream on/off state.
module switch_allocator
    import noc_params::*;
#(
    parameter int unsigned VC_NUM      = noc_params::VC_NUM,
    parameter int unsigned PORT_NUM    = noc_params::PORT_NUM,
    localparam int unsigned VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int unsigned PORT_SIZE  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VC_NUM-1:0]    is_empty_i [PORT_NUM],
    input  logic [VC_NUM-1:0]    vc_ready_i [PORT_NUM],
    input  port_t                out_port_i [PORT_NUM][VC_NUM],
    input  logic [VC_SIZE-1:0]   down_vc_i  [PORT_NUM][VC_NUM],
    input  logic [VC_NUM-1:0]    on_off_i   [PORT_NUM],
    output logic                 valid_sel_o [PORT_NUM],
    output logic [VC_SIZE-1:0]   vc_sel_o    [PORT_NUM],
    output logic                 xb_valid_o  [PORT_NUM],
    output logic [PORT_SIZE-1:0] xb_sel_o    [PORT_NUM]
);

    logic [VC_NUM-1:0]    w_onoff   [PORT_NUM];
    logic [VC_NUM-1:0]    w_req     [PORT_NUM];
    logic [VC_NUM-1:0]    w_s1_gnt  [PORT_NUM];
    logic [VC_SIZE-1:0]   w_s1_vc   [PORT_NUM];
    port_t                w_bid_port[PORT_NUM];
    logic [PORT_NUM-1:0]  w_bid;
    logic [PORT_NUM-1:0]  w_s2_req  [PORT_NUM];
    logic [PORT_NUM-1:0]  w_s2_gnt  [PORT_NUM];
    logic [PORT_SIZE-1:0] w_s2_idx  [PORT_NUM];
    logic [PORT_NUM-1:0]  w_in_gnt;
    logic [PORT_NUM-1:0]  w_out_gnt;

    logic [VC_NUM-1:0]    r_mask    [PORT_NUM];
    logic [PORT_NUM-1:0]  r_valid_sel;
    logic [VC_SIZE-1:0]   r_vc_sel  [PORT_NUM];
    logic [PORT_NUM-1:0]  r_xb_valid;
    logic [PORT_SIZE-1:0] r_xb_sel  [PORT_NUM];

`ifdef SA_ONOFF_FILTER_EN
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                w_onoff[i][v] = (32'(out_port_i[i][v]) < PORT_NUM) ?
                    on_off_i[out_port_i[i][v]][down_vc_i[i][v]] : 1'b0;
            end
        end
    end
`else
    logic w_unused_onoff;

    always_comb begin
        w_unused_onoff = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            w_onoff[i] = '1;
            w_unused_onoff = w_unused_onoff ^ (^on_off_i[i]);
            for (int v = 0; v < VC_NUM; v++) begin
                w_unused_onoff = w_unused_onoff ^ (^down_vc_i[i][v]);
            end
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            w_req[i] = ~is_empty_i[i] & vc_ready_i[i] & ~r_mask[i] & w_onoff[i];
        end
    end

    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_stage1
        round_robin_arbiter #(
            .N(VC_NUM)
        ) u_vc_arb (
            .clk        (clk),
            .rst        (rst),
            .requests_i (w_req[gi]),
            .update_i   (w_in_gnt[gi]),
            .grant_o    (w_s1_gnt[gi])
        );
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            w_s1_vc[i] = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_s1_gnt[i][v]) begin
                    w_s1_vc[i] = VC_SIZE'(v);
                end
            end
            w_bid[i]      = |w_s1_gnt[i];
            w_bid_port[i] = out_port_i[i][w_s1_vc[i]];
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                w_s2_req[o][i] = w_bid[i] && (32'(w_bid_port[i]) == 32'(o));
            end
        end
    end

    for (genvar go = 0; go < PORT_NUM; go++) begin : g_stage2
        round_robin_arbiter #(
            .N(PORT_NUM)
        ) u_port_arb (
            .clk        (clk),
            .rst        (rst),
            .requests_i (w_s2_req[go]),
            .update_i   (w_out_gnt[go]),
            .grant_o    (w_s2_gnt[go])
        );
    end

    // An input wins only if some output arbiter picked it.
    always_comb begin
        w_in_gnt = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            w_out_gnt[o] = |w_s2_gnt[o];
            w_s2_idx[o]  = '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (w_s2_gnt[o][i]) begin
                    w_s2_idx[o] = PORT_SIZE'(i);
                    w_in_gnt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_sel <= '0;
            r_xb_valid  <= '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                r_mask[i]   <= '0;
                r_vc_sel[i] <= '0;
                r_xb_sel[i] <= '0;
            end
        end else begin
            r_valid_sel <= w_in_gnt;
            r_xb_valid  <= w_out_gnt;
            for (int i = 0; i < PORT_NUM; i++) begin
                r_mask[i] <= w_in_gnt[i] ? w_s1_gnt[i] : '0;
                if (w_in_gnt[i]) begin
                    r_vc_sel[i] <= w_s1_vc[i];
                end
                if (w_out_gnt[i]) begin
                    r_xb_sel[i] <= w_s2_idx[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            valid_sel_o[i] = r_valid_sel[i];
            vc_sel_o[i]    = r_vc_sel[i];
            xb_valid_o[i]  = r_xb_valid[i];
            xb_sel_o[i]    = r_xb_sel[i];
        end
    end

endmodule
